// File: rtl/ref_clk_monitor.sv
// Reference clock presence/frequency monitor with hysteresis qualification
// and priority-based automatic source selection (channel 0 is failsafe).
module ref_clk_monitor #(
    parameter int N           = 2,
    parameter int GATE_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int COUNT_MIN   = 9,
    parameter int COUNT_MAX   = 12,
    parameter int HYST_WIDTH  = 7,
    parameter int SYNC_STAGES = 3,
    parameter int SEL_WIDTH   = (N > 2) ? $clog2(N) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N-1:0]               ref_toggle_i,
    input  logic [N-1:0]               chan_enable_i,
    input  logic [N-1:0]               chan_ready_i,
    output logic [N-1:0]               ref_valid_o,
    output logic [N*COUNT_WIDTH-1:0]   ref_count_o,
    output logic                       gate_strobe_o,
    output logic [SEL_WIDTH-1:0]       sel_o,
    output logic                       sel_changed_o
);

    typedef logic [COUNT_WIDTH-1:0] cnt_t;
    typedef logic [HYST_WIDTH-1:0]  hyst_t;

    localparam cnt_t  CNT_SAT   = '1;
    localparam cnt_t  CNT_MIN   = cnt_t'(COUNT_MIN);
    localparam cnt_t  CNT_MAX   = cnt_t'(COUNT_MAX);
    localparam hyst_t HYST_FULL = '1;

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [N-1:0]           last_q;
    logic [N-1:0]           tog_edge;

    logic [GATE_WIDTH-1:0]  gate_q;
    logic                   gate_end;
    logic                   strobe_q;

    cnt_t   cnt_q    [N];
    cnt_t   cnt_d    [N];
    cnt_t   refcnt_q [N];
    cnt_t   refcnt_d [N];
    hyst_t  hyst_q   [N];
    hyst_t  hyst_d   [N];
    logic [N-1:0] valid_q, valid_d;
    logic [N-1:0] arm_q, arm_d;

    logic [SEL_WIDTH-1:0] cand;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 chg_q;
    logic                 unused_ready;

    assign unused_ready = chan_ready_i[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= '0;
            end
            last_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], ref_toggle_i[i]};
                last_q[i] <= sync_q[i][SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        tog_edge = '0;
        for (int i = 0; i < N; i++) begin
            tog_edge[i] = sync_q[i][SYNC_STAGES-1] ^ last_q[i];
        end
    end

    assign gate_end = &gate_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            gate_q   <= gate_q + 1'b1;
            strobe_q <= gate_end;
        end
    end

    // arm_q marks that the current gate started with the channel enabled,
    // so a partial gate after re-enable is never evaluated.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i]    = cnt_q[i];
            refcnt_d[i] = refcnt_q[i];
            hyst_d[i]   = hyst_q[i];
        end
        valid_d = valid_q;
        arm_d   = arm_q;
        for (int i = 0; i < N; i++) begin
            if (!chan_enable_i[i]) begin
                cnt_d[i]    = '0;
                refcnt_d[i] = '0;
                hyst_d[i]   = '0;
                valid_d[i]  = 1'b0;
                arm_d[i]    = 1'b0;
            end else if (gate_end) begin
                cnt_d[i] = cnt_t'(tog_edge[i]);
                arm_d[i] = 1'b1;
                if (arm_q[i]) begin
                    refcnt_d[i] = cnt_q[i];
                    if (cnt_q[i] >= CNT_MIN && cnt_q[i] <= CNT_MAX) begin
                        if (hyst_q[i] != HYST_FULL) begin
                            hyst_d[i] = hyst_q[i] + hyst_t'(1);
                        end
                        valid_d[i] = valid_q[i] | (hyst_d[i] == HYST_FULL);
                    end else begin
                        if (hyst_q[i] != '0) begin
                            hyst_d[i] = hyst_q[i] - hyst_t'(1);
                        end
                        valid_d[i] = valid_q[i] & (hyst_d[i] != '0);
                    end
                end
            end else if (tog_edge[i] && cnt_q[i] != CNT_SAT) begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]    <= '0;
                refcnt_q[i] <= '0;
                hyst_q[i]   <= '0;
            end
            valid_q <= '0;
            arm_q   <= '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]    <= cnt_d[i];
                refcnt_q[i] <= refcnt_d[i];
                hyst_q[i]   <= hyst_d[i];
            end
            valid_q <= valid_d;
            arm_q   <= arm_d;
        end
    end

    // Highest qualified-and-ready channel wins; channel 0 is unconditional.
    always_comb begin
        cand = '0;
        for (int i = 1; i < N; i++) begin
            if (valid_q[i] && chan_ready_i[i]) begin
                cand = SEL_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
            chg_q <= 1'b0;
        end else begin
            sel_q <= cand;
            chg_q <= (cand != sel_q);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign ref_count_o[g*COUNT_WIDTH +: COUNT_WIDTH] = refcnt_q[g];
    end

    assign ref_valid_o   = valid_q;
    assign gate_strobe_o = strobe_q;
    assign sel_o         = sel_q;
    assign sel_changed_o = chg_q;

endmodule
